// File: rtl/interrupt_8259a_pkg.sv
// interrupt_8259a_pkg: shared state encoding and priority helpers for the 8259A interrupt service logic
package interrupt_8259a_pkg;
  typedef enum logic [1:0] {IDLE, ACK1_HELD, WAIT_ACK2, ACK2_HELD} service_state_t;
  function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
    return (v >> n) | (v << (4'd8 - {1'b0, n}));
  endfunction
  function automatic logic [7:0] onehot8(input logic [2:0] i);
    return 8'b1 << i;
  endfunction
endpackage

// File: rtl/priority_resolver_8259a.sv
// priority_resolver_8259a: rotating fully-nested winner selection against the in-service register
module priority_resolver_8259a
  import interrupt_8259a_pkg::*;
(
  input  logic [7:0] candidates,
  input  logic [7:0] isr,
  input  logic [2:0] lowest_priority,
  output logic       winner_valid,
  output logic [2:0] winner_id,
  output logic [2:0] highest_isr_id
);
  logic [2:0] base, c_rank, i_rank;
  logic [7:0] rc, ri;
  // Rotating so bit 0 is the highest-priority level turns priority into plain bit rank
  always_comb begin
    base = lowest_priority + 3'd1;
    rc = rotate_right(candidates, base);
    ri = rotate_right(isr, base);
    c_rank = 3'd0;
    i_rank = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rc[k]) c_rank = k[2:0];
      if (ri[k]) i_rank = k[2:0];
    end
    winner_valid = |rc && (~|ri || c_rank < i_rank);
    winner_id = c_rank + base;
    highest_isr_id = i_rank + base;
  end
endmodule

// File: rtl/interrupt_service_8259a.sv
// interrupt_service_8259a: resolves, acknowledges and tracks 8259A interrupts (ISR, EOI, INTA sequence)
module interrupt_service_8259a
  import interrupt_8259a_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic       interrupt_acknowledge_n,
  input  logic       auto_eoi_config,
  input  logic       auto_rotate_config,
  input  logic [4:0] vector_base,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  input  logic       set_priority_valid,
  input  logic [2:0] set_priority_level,
  output logic       interrupt_out,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_valid
);
  service_state_t state, state_n;
  logic inta_d, fall, rise, win_valid, first_ack, eoi_hit, auto_eoi;
  logic [2:0] lowest_priority, lowest_n, id, id_n, win_id, hi_id, eoi_lvl;
  logic [7:0] isr_n;
  priority_resolver_8259a u_resolver (
    .candidates     (interrupt_request_register & ~interrupt_mask),
    .isr            (in_service_register),
    .lowest_priority(lowest_priority),
    .winner_valid   (win_valid),
    .winner_id      (win_id),
    .highest_isr_id (hi_id)
  );
  always_comb begin
    fall = inta_d & ~interrupt_acknowledge_n;
    rise = ~inta_d & interrupt_acknowledge_n;
    state_n = (state == IDLE && fall) ? ACK1_HELD :
              (state == ACK1_HELD && rise) ? WAIT_ACK2 :
              (state == WAIT_ACK2 && fall) ? ACK2_HELD :
              (state == ACK2_HELD && rise) ? IDLE : state;
    first_ack = state == IDLE && fall;
    id_n = first_ack ? (win_valid ? win_id : 3'd7) : id;
    eoi_lvl = eoi_specific ? eoi_level : hi_id;
    eoi_hit = eoi_valid && in_service_register[eoi_lvl];
    auto_eoi = state == ACK2_HELD && rise && auto_eoi_config;
    isr_n = in_service_register;
    lowest_n = lowest_priority;
    // EOI works on the pre-edge ISR; the new in-service bit lands last, set-priority overrides rotation
    if (auto_eoi) begin
      isr_n = isr_n & ~onehot8(id);
      if (auto_rotate_config) lowest_n = id;
    end
    if (eoi_hit) begin
      isr_n = isr_n & ~onehot8(eoi_lvl);
      if (eoi_rotate) lowest_n = eoi_lvl;
    end
    if (set_priority_valid) lowest_n = set_priority_level;
    if (first_ack && win_valid) isr_n = isr_n | onehot8(win_id);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inta_d <= 1'b1;
      id <= 3'd0;
      lowest_priority <= 3'd7;
      in_service_register <= 8'h00;
      interrupt_out <= 1'b0;
      freeze <= 1'b0;
      clear_interrupt_request <= 8'h00;
      vector_out <= 8'h00;
      vector_valid <= 1'b0;
    end else begin
      inta_d <= interrupt_acknowledge_n;
      id <= id_n;
      lowest_priority <= lowest_n;
      in_service_register <= isr_n;
      interrupt_out <= state_n == IDLE && win_valid;
      freeze <= state != IDLE || state_n != IDLE;
      clear_interrupt_request <= (first_ack && win_valid) ? onehot8(win_id) : 8'h00;
      vector_out <= (state_n == ACK2_HELD) ? {vector_base, id_n} : 8'h00;
      vector_valid <= state_n == ACK2_HELD;
    end
  end
endmodule

// File: tb/tb_interrupt_service_8259a.sv
// tb_interrupt_service_8259a: directed checks of acknowledge, nesting, EOI, rotation and reset behaviour
module tb_interrupt_service_8259a;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] irr = 8'h00;
  logic [7:0] mask = 8'h00;
  logic inta_n = 1'b1;
  logic auto_eoi = 1'b0;
  logic auto_rot = 1'b0;
  logic [4:0] vbase = 5'h11;
  logic eoi_v = 1'b0;
  logic eoi_s = 1'b0;
  logic eoi_r = 1'b0;
  logic [2:0] eoi_l = 3'd0;
  logic sp_v = 1'b0;
  logic [2:0] sp_l = 3'd0;
  logic int_o, frz, vv_o;
  logic [7:0] clr_o, isr_o, vec_o;
  int total = 0;
  int bad = 0;
  logic [7:0] c_clr, c_isr, c_vec;
  logic c_fz, c_vv;
  always #5 clock = ~clock;
  interrupt_service_8259a dut (
    .clock(clock), .reset_n(reset_n),
    .interrupt_request_register(irr), .interrupt_mask(mask),
    .interrupt_acknowledge_n(inta_n),
    .auto_eoi_config(auto_eoi), .auto_rotate_config(auto_rot),
    .vector_base(vbase),
    .eoi_valid(eoi_v), .eoi_specific(eoi_s), .eoi_rotate(eoi_r), .eoi_level(eoi_l),
    .set_priority_valid(sp_v), .set_priority_level(sp_l),
    .interrupt_out(int_o), .freeze(frz), .clear_interrupt_request(clr_o),
    .in_service_register(isr_o), .vector_out(vec_o), .vector_valid(vv_o)
  );
  task automatic cyc();
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Two INTA pulses; the IRR stage's clear is emulated by dropping the cleared bit
  task automatic ack_seq(output logic [7:0] clr, output logic [7:0] isr1, output logic fz,
                         output logic [7:0] vec, output logic vv);
    inta_n = 1'b0;
    cyc();
    clr = clr_o;
    isr1 = isr_o;
    irr = irr & ~clr_o;
    inta_n = 1'b1;
    cyc();
    fz = frz;
    inta_n = 1'b0;
    cyc();
    vec = vec_o;
    vv = vv_o;
    fz = fz & frz;
    inta_n = 1'b1;
    cyc();
    cyc();
  endtask
  task automatic eoi(input logic s, input logic r, input logic [2:0] l);
    eoi_v = 1'b1; eoi_s = s; eoi_r = r; eoi_l = l;
    cyc();
    eoi_v = 1'b0; eoi_s = 1'b0; eoi_r = 1'b0;
  endtask
  initial begin
    cyc();
    chk("rst_int", {7'd0, int_o}, 8'h00);
    chk("rst_freeze", {7'd0, frz}, 8'h00);
    chk("rst_clear", clr_o, 8'h00);
    chk("rst_isr", isr_o, 8'h00);
    chk("rst_vec", vec_o, 8'h00);
    chk("rst_vv", {7'd0, vv_o}, 8'h00);
    reset_n = 1'b1;
    cyc();
    irr = 8'h28;
    cyc();
    chk("basic_int", {7'd0, int_o}, 8'h01);
    inta_n = 1'b0;
    cyc();
    chk("basic_clear", clr_o, 8'h08);
    chk("basic_isr", isr_o, 8'h08);
    chk("basic_freeze1", {7'd0, frz}, 8'h01);
    chk("basic_int_low", {7'd0, int_o}, 8'h00);
    irr = 8'h20;
    cyc();
    chk("basic_clear_1cyc", clr_o, 8'h00);
    inta_n = 1'b1;
    cyc();
    chk("basic_freeze2", {7'd0, frz}, 8'h01);
    inta_n = 1'b0;
    cyc();
    chk("basic_vec", vec_o, 8'h8B);
    chk("basic_vv", {7'd0, vv_o}, 8'h01);
    chk("basic_freeze3", {7'd0, frz}, 8'h01);
    inta_n = 1'b1;
    cyc();
    cyc();
    chk("basic_freeze_end", {7'd0, frz}, 8'h00);
    chk("basic_vv_end", {7'd0, vv_o}, 8'h00);
    chk("basic_isr_kept", isr_o, 8'h08);
    irr = 8'h40;
    cyc(); cyc(); cyc();
    chk("nest_ir6_no_int", {7'd0, int_o}, 8'h00);
    irr = 8'h42;
    cyc();
    chk("nest_ir1_int", {7'd0, int_o}, 8'h01);
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("nest_clear", c_clr, 8'h02);
    chk("nest_isr", c_isr, 8'h0A);
    chk("nest_vec", c_vec, 8'h89);
    chk("nest_freeze", {7'd0, c_fz}, 8'h01);
    eoi(1'b0, 1'b0, 3'd0);
    chk("ns_eoi_isr", isr_o, 8'h08);
    irr = 8'h00;
    eoi(1'b1, 1'b0, 3'd3);
    chk("sp_eoi_isr", isr_o, 8'h00);
    irr = 8'h04;
    cyc();
    chk("spur_int", {7'd0, int_o}, 8'h01);
    irr = 8'h00;
    cyc();
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("spur_clear", c_clr, 8'h00);
    chk("spur_isr", c_isr, 8'h00);
    chk("spur_vec", c_vec, 8'h8F);
    chk("spur_vv", {7'd0, c_vv}, 8'h01);
    irr = 8'h10;
    cyc();
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("rot_isr_set", c_isr, 8'h10);
    eoi(1'b0, 1'b1, 3'd0);
    chk("rot_eoi_isr", isr_o, 8'h00);
    irr = 8'h21;
    cyc();
    chk("rot_int", {7'd0, int_o}, 8'h01);
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("rot_ir5_wins", c_clr, 8'h20);
    chk("rot_vec", c_vec, 8'h8D);
    chk("rot_ir0_held_off", {7'd0, int_o}, 8'h00);
    irr = 8'h00;
    eoi(1'b1, 1'b0, 3'd5);
    chk("rot_sp_eoi", isr_o, 8'h00);
    auto_eoi = 1'b1;
    auto_rot = 1'b1;
    irr = 8'h04;
    cyc();
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("aeoi_clear", c_clr, 8'h04);
    chk("aeoi_isr_mid", c_isr, 8'h04);
    chk("aeoi_vec", c_vec, 8'h8A);
    chk("aeoi_isr_end", isr_o, 8'h00);
    irr = 8'h0C;
    cyc();
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("aeoi_rot_ir3_wins", c_clr, 8'h08);
    irr = 8'h00;
    auto_eoi = 1'b0;
    auto_rot = 1'b0;
    cyc();
    sp_v = 1'b1;
    sp_l = 3'd6;
    cyc();
    sp_v = 1'b0;
    irr = 8'h81;
    cyc();
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("setpri_ir7_wins", c_clr, 8'h80);
    chk("setpri_isr", c_isr, 8'h80);
    sp_v = 1'b1;
    sp_l = 3'd0;
    eoi(1'b0, 1'b1, 3'd0);
    sp_v = 1'b0;
    chk("simul_isr", isr_o, 8'h00);
    irr = 8'h03;
    cyc();
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("simul_setpri_wins", c_clr, 8'h02);
    irr = 8'h00;
    eoi(1'b1, 1'b0, 3'd1);
    chk("simul_cleanup", isr_o, 8'h00);
    irr = 8'h02;
    cyc();
    chk("mid_int", {7'd0, int_o}, 8'h01);
    inta_n = 1'b0;
    cyc();
    chk("mid_isr", isr_o, 8'h02);
    irr = 8'h00;
    inta_n = 1'b1;
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_freeze", {7'd0, frz}, 8'h00);
    chk("mid_rst_isr", isr_o, 8'h00);
    chk("mid_rst_int", {7'd0, int_o}, 8'h00);
    chk("mid_rst_clear", clr_o, 8'h00);
    chk("mid_rst_vec", vec_o, 8'h00);
    chk("mid_rst_vv", {7'd0, vv_o}, 8'h00);
    cyc();
    reset_n = 1'b1;
    irr = 8'h02;
    cyc();
    chk("post_rst_int", {7'd0, int_o}, 8'h01);
    ack_seq(c_clr, c_isr, c_fz, c_vec, c_vv);
    chk("post_rst_clear", c_clr, 8'h02);
    chk("post_rst_isr", c_isr, 8'h02);
    chk("post_rst_vec", c_vec, 8'h89);
    chk("post_rst_freeze", {7'd0, c_fz}, 8'h01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/interrupt_service_8259a.md
# interrupt_service_8259a

- Resolves, acknowledges and tracks interrupts for the 8259A core.
- Sits directly downstream of the interrupt request register (IRR) stage:
  - applies the mask and rotating fully-nested priority to the IRR contents, raises the CPU interrupt, and runs the two-pulse INTA sequence;
  - holds the in-service register (ISR), executes EOI and priority commands, and drives the IRR stage's freeze and clear inputs.

## Interface
- No parameters.
- clock  in  1  single core clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- interrupt_request_register  in  8  IRR contents from the request stage
- interrupt_mask  in  8  OCW1 mask; 1 = masked
- interrupt_acknowledge_n  in  1  CPU INTA, already synchronised to clock, active-low
- auto_eoi_config  in  1  1 = automatic EOI at end of second INTA pulse
- auto_rotate_config  in  1  1 = rotate on automatic EOI
- vector_base  in  5  ICW2 T7..T3
- eoi_valid  in  1  one-cycle OCW2 EOI command strobe
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific
- eoi_rotate  in  1  1 = rotate priority to the cleared level
- eoi_level  in  3  level for specific EOI
- set_priority_valid  in  1  one-cycle set-priority strobe
- set_priority_level  in  3  new lowest-priority level
- interrupt_out  out  1  INT to CPU
- freeze  out  1  to IRR stage; holds IRR during acknowledge
- clear_interrupt_request  out  8  to IRR stage; one-hot, one-cycle clear
- in_service_register  out  8  ISR contents
- vector_out  out  8  interrupt vector
- vector_valid  out  1  vector_out is driven

## Operation
- Candidate set is interrupt_request_register AND NOT interrupt_mask.
- lowest_priority (3 bits, reset 7) defines the priority order, highest first: lowest_priority+1, lowest_priority+2, … wrapping mod 8.
- Winner: first candidate in that order, accepted only if its priority is strictly higher than the highest set ISR bit (fully nested).
- States:
  - IDLE → ACK1_HELD on INTA falling edge.
  - ACK1_HELD → WAIT_ACK2 on INTA rising edge.
  - WAIT_ACK2 → ACK2_HELD on INTA falling edge.
  - ACK2_HELD → IDLE on INTA rising edge.
- First INTA falling edge (IDLE):
  - latch winner id;
  - set that ISR bit;
  - pulse clear_interrupt_request[id] for exactly one cycle.
- No winner at the first falling edge (spurious acknowledge): latch id 7, leave ISR unchanged, no clear pulse.
- ACK2_HELD: vector_out = {vector_base, id}, vector_valid = 1.
- Leaving ACK2_HELD with auto_eoi_config = 1:
  - clear ISR[id];
  - if auto_rotate_config = 1, also set lowest_priority to id.
- Non-specific EOI clears the highest-priority set ISR bit; with no ISR bit set it is a no-op.
- Specific EOI clears ISR[eoi_level].
- eoi_rotate = 1: lowest_priority becomes the cleared level. No bit cleared means no rotation.
- set_priority_valid: lowest_priority <= set_priority_level.
- Simultaneous events:
  - EOI in the same cycle as the first INTA edge: the EOI acts on the pre-edge ISR, then the new bit is set.
  - eoi_rotate together with set_priority_valid: set_priority wins.

## Timing
- Reset values:
  - state IDLE;
  - ISR 0x00, lowest_priority 7;
  - interrupt_out, freeze, vector_valid 0;
  - clear_interrupt_request 0x00, vector_out 0x00.
- interrupt_out is registered:
  - high the cycle after a winner exists in IDLE;
  - forced low from the first falling edge until the return to IDLE.
- freeze is registered: high from the cycle after the first falling edge through the cycle the state returns to IDLE.
- clear_interrupt_request is high the cycle after the first falling edge, for one cycle.
- ISR update and vector are registered:
  - ISR bit set is visible the cycle after the first falling edge;
  - vector_valid is high the cycle after the second falling edge until the cycle after the second rising edge.
- INTA edge detection uses a one-cycle delayed copy of interrupt_acknowledge_n. The delayed copy resets to 1.
- Reset mid-sequence: the block returns to IDLE immediately and releases freeze. The ISR bit set by the first pulse is lost.

## Structure
- Shared package interrupt_8259a_pkg holds:
  - the state enum for the four states;
  - the priority-rotate helper function;
  - an 8-bit one-hot decode function.
- One combinational sub-module, priority_resolver_8259a:
  - inputs: candidates, ISR, lowest_priority;
  - outputs: winner-valid, winner id, highest-ISR id.
  - Instantiated once for request resolution; highest-ISR id also drives non-specific EOI.

## Test plan
- Basic acknowledge:
  - Stimulus: IRR=0x28, mask=0x00, reset priority, two INTA pulses.
  - Required: INT high, clear=0x08 for one cycle, ISR=0x08, vector_out={vector_base,3'd3}, freeze high throughout.
- Nesting:
  - Stimulus: ISR=0x08, IRR=0x40, then IRR=0x02.
  - Required: IR6 never raises INT; IR1 raises INT and ISR becomes 0x0A after acknowledge.
- Spurious acknowledge:
  - Stimulus: IRR clears before the first INTA pulse.
  - Required: vector id 7, ISR unchanged, clear=0x00.
- Rotating EOI:
  - Stimulus: ISR=0x10, non-specific EOI with rotate.
  - Required: ISR=0x00, lowest_priority=4; with IRR=0x21, IR5 wins over IR0.
- Automatic EOI with rotation:
  - Stimulus: auto_eoi_config=1, auto_rotate_config=1, acknowledge IR2.
  - Required: ISR returns to 0x00 after the second pulse; lowest_priority=2.
- Reset mid-sequence:
  - Stimulus: reset_n low between the two INTA pulses.
  - Required: all outputs at reset values asynchronously; a new sequence after reset completes normally.
